hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller; produces the PCWrite enable consumed by the PC register, plus IF/ID write-enable,
//  ID/EX bubble-insert and IF/ID flush. Detects load-use hazards and ID-stage branch operand hazards, sequences
//  multi-cycle stalls with a small FSM, and holds the front end for one cycle after reset release.
// PARAMETERS
//  REG_W   5   register-index width
//  CNT_W   16  width of statistics counters (used only with HAZ_STATS_EN)
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      reset, asynchronous, active-low
//  id_rs, id_rt     in   REG_W  source registers of instruction in ID
//  id_uses_rt       in   1      ID instruction reads rt as a source
//  id_branch        in   1      ID holds beq/bne (resolved in ID)
//  id_branch_taken  in   1      ID comparison result; meaningful only when no hazard
//  id_jump          in   1      ID holds j/jal
//  ex_mem_read      in   1      ID/EX instruction is a load
//  ex_reg_write     in   1      ID/EX instruction writes a register
//  ex_rd            in   REG_W  ID/EX destination (post RegDst mux)
//  mem_mem_read     in   1      EX/MEM instruction is a load
//  mem_rd           in   REG_W  EX/MEM destination
//  PCWrite          out  1      PC register load enable
//  IF_ID_Write      out  1      IF/ID register load enable
//  ID_EX_Bubble     out  1      zero ID/EX control bits this cycle
//  IF_Flush         out  1      clear IF/ID instruction to nop
//  stall_cycles     out  CNT_W  HAZ_STATS_EN only
//  flush_count      out  CNT_W  HAZ_STATS_EN only
// BEHAVIOUR
//  Match(x): x!=0 && (x==id_rs || (id_uses_rt && x==id_rt)). Register 0 never hazards.
//  Hazard terms (combinational on inputs):
//   LU  = ex_mem_read && Match(ex_rd)                        -> 1 stall
//   BEX = id_branch && ex_reg_write && !ex_mem_read && Match(ex_rd) -> 1 stall
//   BLE = id_branch && ex_mem_read && Match(ex_rd)           -> 2 stalls (overrides LU)
//   BLM = id_branch && mem_mem_read && Match(mem_rd)         -> 1 stall
//  Stall outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_Flush=0.
//  FSM states BOOT, RUN, HOLD; state register and 2-bit stall_left reset asynchronously.
//   rst_n low: state=BOOT, stall_left=0; outputs forced to stall values immediately (async).
//   BOOT: stall outputs for exactly one cycle after rst_n rises; -> RUN.
//   RUN, any hazard: stall outputs same cycle (Mealy); BLE -> HOLD with stall_left=1; else stay RUN.
//   RUN, no hazard, (id_branch && id_branch_taken) || id_jump: PCWrite=1, IF_ID_Write=1,
//     ID_EX_Bubble=0, IF_Flush=1; stay RUN.
//   RUN, otherwise: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_Flush=0.
//   HOLD: stall outputs regardless of inputs; decrement stall_left; at 0 -> RUN (inputs re-evaluated there).
//  Priority: reset > BOOT/HOLD > hazard > flush. Flush never asserted in a stall cycle.
//  Consecutive hazards: RUN re-evaluates every cycle, so back-to-back stalls are allowed without gaps.
//  Reset mid-HOLD: abandons remaining stall, returns to BOOT.
// CONFIGURATION
//  HAZ_STATS_EN defined: stall_cycles counts every cycle with PCWrite=0 after BOOT (BOOT excluded);
//   flush_count counts cycles with IF_Flush=1; both saturate at all-ones, reset to 0 asynchronously.
//  Undefined: both ports and counters absent; control behaviour identical.
// TESTING
//  1 Reset low 3 cycles, release -> stall values during reset and first post-release cycle, PCWrite=1 on 2nd.
//  2 ex_mem_read=1, ex_rd=8, id_rs=8 -> exactly 1 cycle PCWrite=0/ID_EX_Bubble=1, then PCWrite=1 once inputs clear.
//  3 id_branch=1, ex_mem_read=1, ex_rd=9, id_rt=9, id_uses_rt=1 -> 2 stall cycles (RUN then HOLD), inputs ignored in HOLD.
//  4 id_branch=1, id_branch_taken=1, no matches -> IF_Flush=1, PCWrite=1 for one cycle; with ex_rd=id_rs=5,
//    ex_reg_write=1 same cycle -> stall, IF_Flush=0.
//  5 ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall; assert rst_n low during HOLD -> outputs to stall values instantly, BOOT next.
//  6 HAZ_STATS_EN: run 3 stalls + 2 flushes -> stall_cycles=3, flush_count=2; preload saturation -> holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and ID-branch operand stalls, taken-branch/jump flush, post-reset hold.
// Optional statistics counters are built when HAZ_STATS_EN is defined.
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_Flush
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e     state_r;
  logic [1:0] stall_left_r;

  logic match_ex_s, match_mem_s;
  logic lu_s, bex_s, ble_s, blm_s, hazard_s, redirect_s;

  if (REG_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: REG_W and CNT_W must be positive");
  end

  // Register 0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt, input logic uses_rt);
    return (x != {REG_W{1'b0}}) && ((x == rs) || (uses_rt && (x == rt)));
  endfunction

  // Hazard detection on the current ID, EX and MEM contents.
  always_comb begin
    match_ex_s  = reg_match(ex_rd, id_rs, id_rt, id_uses_rt);
    match_mem_s = reg_match(mem_rd, id_rs, id_rt, id_uses_rt);
    lu_s        = ex_mem_read && match_ex_s;
    bex_s       = id_branch && ex_reg_write && !ex_mem_read && match_ex_s;
    ble_s       = id_branch && ex_mem_read && match_ex_s;
    blm_s       = id_branch && mem_mem_read && match_mem_s;
    hazard_s    = lu_s || bex_s || ble_s || blm_s;
    redirect_s  = (id_branch && id_branch_taken) || id_jump;
  end

  // Pipeline control outputs; stall values unless RUN decides otherwise.
  always_comb begin
    PCWrite      = 1'b0;
    IF_ID_Write  = 1'b0;
    ID_EX_Bubble = 1'b1;
    IF_Flush     = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (hazard_s) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          IF_Flush     = 1'b0;
        end else begin
          PCWrite      = 1'b1;
          IF_ID_Write  = 1'b1;
          ID_EX_Bubble = 1'b0;
          IF_Flush     = redirect_s;
        end
      end
      default: begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        IF_Flush     = 1'b0;
      end
    endcase
  end

  // Stall sequencer: BOOT holds one cycle, a branch-after-load adds one HOLD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_BOOT;
      stall_left_r <= 2'd0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r      <= ST_RUN;
          stall_left_r <= 2'd0;
        end
        ST_RUN: begin
          if (ble_s) begin
            state_r      <= ST_HOLD;
            stall_left_r <= 2'd1;
          end else begin
            state_r      <= ST_RUN;
            stall_left_r <= 2'd0;
          end
        end
        ST_HOLD: begin
          if (stall_left_r <= 2'd1) begin
            state_r      <= ST_RUN;
            stall_left_r <= 2'd0;
          end else begin
            state_r      <= ST_HOLD;
            stall_left_r <= stall_left_r - 2'd1;
          end
        end
        default: begin
          state_r      <= ST_BOOT;
          stall_left_r <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  // Saturating counters of post-boot stall cycles and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= {CNT_W{1'b0}};
      flush_count  <= {CNT_W{1'b0}};
    end else begin
      if ((state_r != ST_BOOT) && !PCWrite && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (IF_Flush && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_count <= flush_count;
      end
    end
  end
`endif

endmodule
